// File: rtl/addn_pkg.sv
`default_nettype none
// ============================================================================
// Package : addn_pkg
// Brief   : Shared types and elaboration-time helpers for the sequential
//           N-operand adder (state encoding, log2, beat count, guard bits).
// Revision: 1.0 - initial release
// ============================================================================
package addn_pkg;

  // Controller states; explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Default configuration of the block.
  localparam int DEF_WIDTH = 64;
  localparam int DEF_N     = 7;
  localparam int DEF_LANES = 2;

  // Ceiling log2; clog2_f(1) == 0.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Number of accumulation beats for one job: ceil(n / lanes).
  function automatic int k_f(input int n, input int lanes);
    return (n + lanes - 1) / lanes;
  endfunction

  // Extra sum bits so acc plus LANES operands never wraps inside one beat.
  function automatic int guard_f(input int lanes);
    return clog2_f(lanes + 1);
  endfunction

  // Operand-index counter width; it reaches at most n + lanes - 1.
  function automatic int idx_w_f(input int n, input int lanes);
    int w;
    w = clog2_f(n + lanes);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : addn_pkg
`default_nettype wire

// File: rtl/addn_lane_sum.sv
`default_nettype none
// ============================================================================
// Module  : addn_lane_sum
// Brief   : Combinational partial sum of one beat: the running accumulator
//           plus LANES operands starting at a base index. Lanes that fall at
//           or beyond operand N contribute zero. Output carries guard bits so
//           the caller can see any carry out of WIDTH.
// Revision: 1.0 - initial release
// ============================================================================
module addn_lane_sum
  import addn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int LANES = DEF_LANES,
  parameter int GW    = guard_f(DEF_LANES),
  parameter int IW    = idx_w_f(DEF_N, DEF_LANES)
) (
  input  logic [N*WIDTH-1:0]    ops,
  input  logic [IW-1:0]         base,
  input  logic [WIDTH-1:0]      acc,
  output logic [WIDTH+GW-1:0]   sum
);

  // Add the accumulator and every in-range lane operand, zero-extended.
  always_comb begin
    sum = {{GW{1'b0}}, acc};
    for (int l = 0; l < LANES; l++) begin
      if ((int'(base) + l) < N) begin
        sum = sum + {{GW{1'b0}}, ops[(int'(base) + l)*WIDTH +: WIDTH]};
      end
    end
  end

endmodule : addn_lane_sum
`default_nettype wire

// File: rtl/addn_seq.sv
`default_nettype none
// ============================================================================
// Module  : addn_seq
// Brief   : Sequential N-operand adder. A start pulse latches all operands;
//           the sum is accumulated LANES operands per cycle over
//           ceil(N/LANES) cycles, then a one-cycle done pulse is raised with
//           the WIDTH-bit result and a sticky unsigned-overflow flag.
// Revision: 1.0 - initial release
// ============================================================================
module addn_seq
  import addn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int LANES = DEF_LANES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 r_enable,
  input  logic [N*WIDTH-1:0]   operands,
  output logic                 busy,
  output logic                 w_enable,
  output logic [WIDTH-1:0]     result,
  output logic                 overflow
);

  localparam int GW = guard_f(LANES);
  localparam int IW = idx_w_f(N, LANES);
  localparam int SW = WIDTH + GW;

  state_t               state;
  logic [N*WIDTH-1:0]   ops_q;
  logic [WIDTH-1:0]     acc;
  logic [IW-1:0]        idx;
  logic                 ovf_acc;
  logic [SW-1:0]        lane_sum;
  logic                 sum_carry;
  logic                 last_beat;

  addn_lane_sum #(
    .WIDTH (WIDTH),
    .N     (N),
    .LANES (LANES),
    .GW    (GW),
    .IW    (IW)
  ) u_lane_sum (
    .ops  (ops_q),
    .base (idx),
    .acc  (acc),
    .sum  (lane_sum)
  );

  // Any bit above WIDTH means this beat wrapped the accumulator.
  assign sum_carry = |lane_sum[SW-1:WIDTH];

  // The current beat covers the highest operand index, so the job ends here.
  assign last_beat = (int'(idx) + LANES) >= N;

  // Controller: start/accumulate/done sequencing with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      w_enable <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      acc      <= '0;
      idx      <= '0;
      ovf_acc  <= 1'b0;
      ops_q    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          w_enable <= 1'b0;
          if (r_enable) begin
            // Operands are captured here so the source may change afterwards.
            ops_q   <= operands;
            acc     <= '0;
            idx     <= '0;
            ovf_acc <= 1'b0;
            state   <= ACCUM;
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ACCUM: begin
          // Start requests are ignored while a job is in flight.
          acc     <= lane_sum[WIDTH-1:0];
          ovf_acc <= ovf_acc | sum_carry;
          idx     <= idx + IW'(LANES);
          if (last_beat) begin
            // Result/overflow only change on completion; they hold otherwise.
            result   <= lane_sum[WIDTH-1:0];
            overflow <= ovf_acc | sum_carry;
            state    <= DONE;
            busy     <= 1'b0;
            w_enable <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          w_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule : addn_seq
`default_nettype wire

// File: tb/tb_addn_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_addn_seq
// Brief   : Scoreboard bench for addn_seq in four configurations
//           (64b N7 L2, 8b N3 L2, 64b N7 L1, 64b N7 L7).
// Revision: 1.0 - initial release
// ============================================================================
module tb_addn_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Instance a: WIDTH=64, N=7, LANES=2 (K=4), own reset for abort test
  logic         rst_a, en_a, busy_a, we_a, ovf_a;
  logic [447:0] ops_a;
  logic [63:0]  res_a;
  // Instance b: WIDTH=8, N=3, LANES=2 (K=2)
  logic         en_b, busy_b, we_b, ovf_b;
  logic [23:0]  ops_b;
  logic [7:0]   res_b;
  // Instance c: WIDTH=64, N=7, LANES=1 (K=7)
  logic         en_c, busy_c, we_c, ovf_c;
  logic [447:0] ops_c;
  logic [63:0]  res_c;
  // Instance d: WIDTH=64, N=7, LANES=7 (K=1)
  logic         en_d, busy_d, we_d, ovf_d;
  logic [447:0] ops_d;
  logic [63:0]  res_d;
  logic         rst_n;

  addn_seq #(.WIDTH(64), .N(7), .LANES(2)) u_a (
    .clk(clk), .rst_n(rst_a), .r_enable(en_a), .operands(ops_a),
    .busy(busy_a), .w_enable(we_a), .result(res_a), .overflow(ovf_a));
  addn_seq #(.WIDTH(8), .N(3), .LANES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .r_enable(en_b), .operands(ops_b),
    .busy(busy_b), .w_enable(we_b), .result(res_b), .overflow(ovf_b));
  addn_seq #(.WIDTH(64), .N(7), .LANES(1)) u_c (
    .clk(clk), .rst_n(rst_n), .r_enable(en_c), .operands(ops_c),
    .busy(busy_c), .w_enable(we_c), .result(res_c), .overflow(ovf_c));
  addn_seq #(.WIDTH(64), .N(7), .LANES(7)) u_d (
    .clk(clk), .rst_n(rst_n), .r_enable(en_d), .operands(ops_d),
    .busy(busy_d), .w_enable(we_d), .result(res_d), .overflow(ovf_d));

  typedef struct {
    int          id;
    logic [63:0] res;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input logic [63:0] r, input logic o, input int k);
    exp_t e;
    e.id = id; e.res = r; e.ovf = o; e.due = cyc + 1 + k;
    sb.push_back(e);
  endtask

  function automatic int find_exp(input int id);
    for (int k = 0; k < sb.size(); k++)
      if (sb[k].id == id) return k;
    return -1;
  endfunction

  function automatic logic [447:0] pack7(input logic [63:0] a0, a1, a2, a3, a4, a5, a6);
    return {a6, a5, a4, a3, a2, a1, a0};
  endfunction

  // Monitor: compares every done pulse against the oldest expectation of
  // that instance, and checks outputs hold steady between pulses.
  logic [63:0] last_res [4];
  logic        last_ovf [4];
  always @(negedge clk) begin
    logic        we [4];
    logic [63:0] rs [4];
    logic        ov [4];
    logic        rv [4];
    string       nm [4];
    exp_t        e;
    int          k;
    we[0] = we_a; rs[0] = res_a;            ov[0] = ovf_a; rv[0] = rst_a; nm[0] = "a";
    we[1] = we_b; rs[1] = {56'd0, res_b};   ov[1] = ovf_b; rv[1] = rst_n; nm[1] = "b";
    we[2] = we_c; rs[2] = res_c;            ov[2] = ovf_c; rv[2] = rst_n; nm[2] = "c";
    we[3] = we_d; rs[3] = res_d;            ov[3] = ovf_d; rv[3] = rst_n; nm[3] = "d";
    for (int i = 0; i < 4; i++) begin
      if (!rv[i]) begin
        last_res[i] = '0;
        last_ovf[i] = 1'b0;
      end else begin
        k = find_exp(i);
        if (we[i]) begin
          if (k < 0) begin
            chk({nm[i], "_unexpected_w_enable"}, 64'd1, 64'd0);
          end else begin
            e = sb[k];
            sb.delete(k);
            chk({nm[i], "_result"}, rs[i], e.res);
            chk({nm[i], "_overflow"}, {63'd0, ov[i]}, {63'd0, e.ovf});
            chk({nm[i], "_latency"}, 64'(cyc), 64'(e.due));
            last_res[i] = e.res;
            last_ovf[i] = e.ovf;
          end
        end else begin
          chk({nm[i], "_result_hold"}, rs[i], last_res[i]);
          chk({nm[i], "_overflow_hold"}, {63'd0, ov[i]}, {63'd0, last_ovf[i]});
          if (k >= 0 && cyc > sb[k].due) begin
            chk({nm[i], "_missing_w_enable_at"}, 64'(cyc), 64'(sb[k].due));
            sb.delete(k);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [447:0] o1, o2, o3;

  initial begin
    o1 = pack7(64'd123, 64'd234, 64'd345, 64'd456, 64'd567, 64'd678, 64'd789); // 3192
    o2 = pack7(64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7);                // 28
    o3 = pack7(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd5); // 5, ovf
    rst_a = 1'b0; rst_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
    ops_a = '0; ops_b = '0; ops_c = '0; ops_d = '0;
    repeat (2) tick();
    rst_a = 1'b1; rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset_busy", {63'd0, busy_a}, 64'd0);
    chk("reset_w_enable", {63'd0, we_a}, 64'd0);
    chk("reset_result", res_a, 64'd0);
    chk("reset_overflow", {63'd0, ovf_a}, 64'd0);

    // Single job on every configuration
    tick();
    en_a = 1'b1; ops_a = o1; push(0, 64'd3192, 1'b0, 4);
    en_b = 1'b1; ops_b = {8'd10, 8'd100, 8'd200}; push(1, 64'd54, 1'b1, 2);
    en_c = 1'b1; ops_c = o1; push(2, 64'd3192, 1'b0, 7);
    en_d = 1'b1; ops_d = o1; push(3, 64'd3192, 1'b0, 1);
    tick();
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
    ops_a = o3; ops_b = '1; ops_c = o3; ops_d = o3;
    @(negedge clk);
    chk("busy_in_accum", {63'd0, busy_a}, 64'd1);
    repeat (10) tick();
    chk("busy_after_done", {63'd0, busy_a}, 64'd0);

    // Start request during ACCUM is ignored
    en_a = 1'b1; ops_a = o1; push(0, 64'd3192, 1'b0, 4);
    tick();
    en_a = 1'b0; ops_a = o2;
    tick();
    en_a = 1'b1;
    tick();
    en_a = 1'b0;
    repeat (8) tick();

    // Reset mid-ACCUM aborts the job, then a fresh job completes
    en_a = 1'b1; ops_a = o2;
    tick();
    en_a = 1'b0;
    tick();
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy_a}, 64'd0);
    chk("abort_w_enable", {63'd0, we_a}, 64'd0);
    chk("abort_result", res_a, 64'd0);
    chk("abort_overflow", {63'd0, ovf_a}, 64'd0);
    repeat (8) tick();
    en_a = 1'b1; ops_a = o1; push(0, 64'd3192, 1'b0, 4);
    tick();
    en_a = 1'b0;
    repeat (8) tick();

    // Back-to-back jobs with r_enable held high: one completion per 5 cycles
    en_a = 1'b1;
    for (int j = 0; j < 3; j++) begin
      case (j)
        0: begin ops_a = o1; push(0, 64'd3192, 1'b0, 4); end
        1: begin ops_a = o2; push(0, 64'd28, 1'b0, 4); end
        default: begin ops_a = o3; push(0, 64'd5, 1'b1, 4); end
      endcase
      tick();
      ops_a = {448{1'b1}};
      repeat (4) tick();
    end
    en_a = 1'b0;
    repeat (10) tick();

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_addn_seq
`default_nettype wire
